// File: rtl/keycode_pkg.sv
// Shared constants and helpers for the keycode lock: FSM state encoding,
// a ceil(log2) helper and the width of the shared tick timer.
package keycode_pkg;

  // FSM state encoding (3 bits, kept as plain constants for legacy tools)
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTRY   = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] OPEN    = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;

  // Number of bits needed to hold values 0..value-1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a timer that must be able to count up to the largest limit
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return clog2(m + 1);
  endfunction

  // Timer width for the default limits (16 / 8 / 32 ticks)
  localparam int TIMER_W = timer_width(16, 8, 32);

endpackage

// File: rtl/keycode_lock_if.sv
// Key inputs, timebase strobe and status outputs of the keycode lock.
interface keycode_lock_if #(
  parameter int CNT_W = 3
);
  logic             tick;
  logic             X0_deb;
  logic             X1_deb;
  logic             unlock;
  logic             alarm;
  logic             err_pulse;
  logic [CNT_W-1:0] entry_cnt;
  logic [3:0]       tries_left;

  modport master (
    output tick, X0_deb, X1_deb,
    input  unlock, alarm, err_pulse, entry_cnt, tries_left
  );

  modport slave (
    input  tick, X0_deb, X1_deb,
    output unlock, alarm, err_pulse, entry_cnt, tries_left
  );
endinterface

// File: rtl/tick_counter.sv
// Counts timebase ticks up to a limit; shared by the entry timeout, the open
// window and the lockout period. Saturates at the limit until cleared.
module tick_counter
  import keycode_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_r;

  assign done = (count_r == limit);

  // Tick accumulator: clear wins over tick, hold once the limit is reached
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (tick && !done) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/keycode_lock.sv
// Keycode lock: shifts debounced 0/1 key pulses into an entry, compares it
// against a fixed code, opens on a match and locks out after too many misses.
module keycode_lock
  import keycode_pkg::*;
#(
  parameter int                  CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0] CODE          = 4'b1011,
  parameter int                  MAX_TRIES     = 3,
  parameter int                  TIMEOUT_TICKS = 16,
  parameter int                  OPEN_TICKS    = 8,
  parameter int                  LOCK_TICKS    = 32
) (
  input  logic          sysclk,
  input  logic          reset,
  keycode_lock_if.slave bus
);

  localparam int              CNT_W = clog2(CODE_LEN + 1);
  localparam int              TW    = timer_width(TIMEOUT_TICKS, OPEN_TICKS, LOCK_TICKS);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CODE_LEN);
  localparam logic [3:0]      MAX_C = 4'(MAX_TRIES);

  logic [2:0]          state_r;
  logic [2:0]          state_next_s;
  logic [CODE_LEN-1:0] sr_r;
  logic [CODE_LEN-1:0] sr_shift_s;
  logic [CNT_W-1:0]    entry_cnt_r;
  logic [3:0]          tries_r;
  logic                unlock_r;
  logic                alarm_r;
  logic                err_r;
  logic                key_s;
  logic                bit_s;
  logic                match_s;
  logic                shift_s;
  logic                flush_s;
  logic                hold_clr_s;
  logic                timer_clr_s;
  logic                timer_done_s;
  logic [TW-1:0]       limit_s;

  // Exactly one key high is a key event; both high together is ignored
  assign key_s   = bus.X0_deb ^ bus.X1_deb;
  assign bit_s   = bus.X1_deb;
  assign match_s = (sr_r == CODE);

  // Entry shifted left with the new key as LSB (first key ends up as MSB)
  always_comb begin
    sr_shift_s    = sr_r << 1;
    sr_shift_s[0] = bit_s;
  end

  // Next-state and datapath control decisions
  always_comb begin
    state_next_s = state_r;
    shift_s      = 1'b0;
    flush_s      = 1'b0;
    hold_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        hold_clr_s = 1'b1;
        if (key_s) begin
          shift_s      = 1'b1;
          state_next_s = (CODE_LEN == 1) ? CHECK : ENTRY;
        end else begin
          state_next_s = IDLE;
        end
      end
      ENTRY: begin
        if (key_s) begin
          shift_s    = 1'b1;
          hold_clr_s = 1'b1;
          if ((entry_cnt_r + CNT_W'(1)) == LEN_C) begin
            state_next_s = CHECK;
          end else begin
            state_next_s = ENTRY;
          end
        end else if (timer_done_s) begin
          flush_s      = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = ENTRY;
        end
      end
      CHECK: begin
        flush_s    = 1'b1;
        hold_clr_s = 1'b1;
        if (match_s) begin
          state_next_s = OPEN;
        end else if (tries_r == 4'd1) begin
          state_next_s = LOCKOUT;
        end else begin
          state_next_s = IDLE;
        end
      end
      OPEN: begin
        if (timer_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OPEN;
        end
      end
      LOCKOUT: begin
        if (timer_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOCKOUT;
        end
      end
      default: begin
        hold_clr_s   = 1'b1;
        flush_s      = 1'b1;
        state_next_s = IDLE;
      end
    endcase
  end

  // Timer is cleared on every state change and whenever a key restarts it
  assign timer_clr_s = hold_clr_s | (state_next_s != state_r);

  // Select the tick limit that applies to the current state
  always_comb begin
    limit_s = TW'(TIMEOUT_TICKS);
    case (state_r)
      ENTRY:   limit_s = TW'(TIMEOUT_TICKS);
      OPEN:    limit_s = TW'(OPEN_TICKS);
      LOCKOUT: limit_s = TW'(LOCK_TICKS);
      default: limit_s = TW'(TIMEOUT_TICKS);
    endcase
  end

  tick_counter #(.W(TW)) u_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (timer_clr_s),
    .tick   (bus.tick),
    .limit  (limit_s),
    .done   (timer_done_s)
  );

  // State, entry shift register, bit count and remaining tries
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sr_r        <= '0;
      entry_cnt_r <= '0;
      tries_r     <= MAX_C;
    end else begin
      state_r <= state_next_s;
      if (shift_s) begin
        sr_r        <= sr_shift_s;
        entry_cnt_r <= entry_cnt_r + CNT_W'(1);
      end else if (flush_s) begin
        sr_r        <= '0;
        entry_cnt_r <= '0;
      end else begin
        sr_r        <= sr_r;
        entry_cnt_r <= entry_cnt_r;
      end
      if (state_r == CHECK) begin
        tries_r <= match_s ? MAX_C : (tries_r - 4'd1);
      end else if ((state_r == LOCKOUT) && (state_next_s == IDLE)) begin
        tries_r <= MAX_C;
      end else begin
        tries_r <= tries_r;
      end
    end
  end

  // Status outputs registered from the state being entered
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      unlock_r <= 1'b0;
      alarm_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      unlock_r <= (state_next_s == OPEN);
      alarm_r  <= (state_next_s == LOCKOUT);
      err_r    <= (state_r == CHECK) && !match_s;
    end
  end

  assign bus.unlock     = unlock_r;
  assign bus.alarm      = alarm_r;
  assign bus.err_pulse  = err_r;
  assign bus.entry_cnt  = entry_cnt_r;
  assign bus.tries_left = tries_r;

endmodule

// File: tb/tb_keycode_lock.sv
// Directed bench for keycode_lock with a queue-based reference model that is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_keycode_lock;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;

  keycode_lock_if #(.CNT_W(3)) kif ();

  keycode_lock dut (
    .sysclk (clk),
    .reset  (rst),
    .bus    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits entered so far, pending evaluation, open/lockout windows
  int m_bits[$];
  bit m_full, m_open, m_lock, m_err;
  int m_ticks, m_tries;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_bits.delete();
        m_full = 1'b0; m_open = 1'b0; m_lock = 1'b0; m_err = 1'b0;
        m_ticks = 0; m_tries = 3;
      end else begin
        bit key;
        bit tk;
        int value;
        key = kif.X0_deb ^ kif.X1_deb;
        tk  = kif.tick;
        m_err = 1'b0;
        if (m_full) begin
          value = 0;
          foreach (m_bits[i]) value = value * 2 + m_bits[i];
          if (value == 11) begin
            m_open = 1'b1; m_tries = 3;
          end else begin
            m_tries = m_tries - 1; m_err = 1'b1;
            if (m_tries == 0) m_lock = 1'b1;
          end
          m_bits.delete(); m_full = 1'b0; m_ticks = 0;
        end else if (m_open) begin
          if (m_ticks >= 8) begin m_open = 1'b0; m_ticks = 0; end
          else if (tk) m_ticks = m_ticks + 1;
        end else if (m_lock) begin
          if (m_ticks >= 32) begin m_lock = 1'b0; m_ticks = 0; m_tries = 3; end
          else if (tk) m_ticks = m_ticks + 1;
        end else if (key) begin
          m_bits.push_back(int'(kif.X1_deb));
          m_ticks = 0;
          if (m_bits.size() == 4) m_full = 1'b1;
        end else if (m_bits.size() > 0) begin
          if (m_ticks >= 16) begin m_bits.delete(); m_ticks = 0; end
          else if (tk) m_ticks = m_ticks + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("unlock",     int'(kif.unlock),     int'(m_open));
      chk("alarm",      int'(kif.alarm),      int'(m_lock));
      chk("err_pulse",  int'(kif.err_pulse),  int'(m_err));
      chk("entry_cnt",  int'(kif.entry_cnt),  m_bits.size());
      chk("tries_left", int'(kif.tries_left), m_tries);
    end
  end

  task automatic step(input logic a0, input logic a1, input logic t);
    kif.X0_deb = a0; kif.X1_deb = a1; kif.tick = t;
    @(negedge clk);
    kif.X0_deb = 1'b0; kif.X1_deb = 1'b0; kif.tick = 1'b0;
  endtask

  task automatic key(input logic b);
    step(~b, b, 1'b0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic enter(input logic b3, input logic b2, input logic b1, input logic b0);
    key(b3); key(b2); key(b1); key(b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_unlock"},  int'(kif.unlock),     0);
    chk({tag, "_alarm"},   int'(kif.alarm),      0);
    chk({tag, "_err"},     int'(kif.err_pulse),  0);
    chk({tag, "_cnt"},     int'(kif.entry_cnt),  0);
    chk({tag, "_tries"},   int'(kif.tries_left), 3);
  endtask

  initial begin
    checks = 0; errors = 0; started = 1'b0;
    rst = 1'b0;
    kif.X0_deb = 1'b0; kif.X1_deb = 1'b0; kif.tick = 1'b0;
    #2 rst = 1'b1;
    #2 chk_reset_vals("por");
    @(negedge clk); rst = 1'b0; started = 1'b1;
    quiet(2);

    // Correct code 1011
    key(1'b1); chk("ok_cnt1", int'(kif.entry_cnt), 1);
    key(1'b0); chk("ok_cnt2", int'(kif.entry_cnt), 2);
    key(1'b1); chk("ok_cnt3", int'(kif.entry_cnt), 3);
    key(1'b1); chk("ok_t1_unlock", int'(kif.unlock), 0);
    quiet(1);
    chk("ok_t2_unlock", int'(kif.unlock), 1);
    chk("ok_tries", int'(kif.tries_left), 3);
    chk("ok_cnt0", int'(kif.entry_cnt), 0);
    ticks(7); chk("open_7ticks", int'(kif.unlock), 1);
    ticks(1); chk("open_8ticks", int'(kif.unlock), 0);

    // Wrong code 1111
    enter(1'b1, 1'b1, 1'b1, 1'b1);
    chk("bad_t1_err", int'(kif.err_pulse), 0);
    quiet(1);
    chk("bad_t2_err", int'(kif.err_pulse), 1);
    chk("bad_tries", int'(kif.tries_left), 2);
    chk("bad_unlock", int'(kif.unlock), 0);
    quiet(1);
    chk("bad_err_once", int'(kif.err_pulse), 0);

    // Two more misses lead to lockout
    enter(1'b0, 1'b0, 1'b0, 1'b0); quiet(1);
    chk("bad2_tries", int'(kif.tries_left), 1);
    enter(1'b1, 1'b1, 1'b0, 1'b0); quiet(1);
    chk("bad3_tries", int'(kif.tries_left), 0);
    chk("lock_alarm", int'(kif.alarm), 1);
    enter(1'b1, 1'b0, 1'b1, 1'b1);
    chk("lock_keys_cnt", int'(kif.entry_cnt), 0);
    chk("lock_keys_unlock", int'(kif.unlock), 0);
    ticks(31); chk("lock_31", int'(kif.alarm), 1);
    ticks(1);
    chk("lock_32", int'(kif.alarm), 0);
    chk("lock_tries", int'(kif.tries_left), 3);
    enter(1'b1, 1'b0, 1'b1, 1'b1); quiet(1);
    chk("post_lock_unlock", int'(kif.unlock), 1);
    ticks(8);

    // Inactivity timeout discards the partial entry
    key(1'b1); key(1'b0);
    ticks(15); chk("to_15", int'(kif.entry_cnt), 2);
    ticks(1);
    chk("to_16_cnt", int'(kif.entry_cnt), 0);
    chk("to_16_tries", int'(kif.tries_left), 3);

    // Key on the 15th tick restarts the timer; entry completes
    key(1'b1); key(1'b0);
    ticks(14);
    step(1'b0, 1'b1, 1'b1);
    chk("to_key_cnt", int'(kif.entry_cnt), 3);
    ticks(15); chk("to_restart_cnt", int'(kif.entry_cnt), 3);
    key(1'b1); quiet(1);
    chk("to_restart_unlock", int'(kif.unlock), 1);
    ticks(8);

    // Both keys together are ignored
    key(1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("both_cnt", int'(kif.entry_cnt), 1);
    key(1'b0); key(1'b1); key(1'b1); quiet(1);
    chk("both_unlock", int'(kif.unlock), 1);
    ticks(8);

    // Asynchronous reset mid-entry
    key(1'b1); key(1'b0);
    chk("pre_rst_cnt", int'(kif.entry_cnt), 2);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_entry");
    @(negedge clk); rst = 1'b0;
    quiet(1);

    // Asynchronous reset during lockout
    enter(1'b0, 1'b0, 1'b0, 1'b1); quiet(1);
    enter(1'b0, 1'b0, 1'b1, 1'b0); quiet(1);
    enter(1'b0, 1'b1, 1'b0, 1'b0); quiet(1);
    chk("pre_rst_alarm", int'(kif.alarm), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_lock");
    @(negedge clk); rst = 1'b0;
    quiet(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_lock.md
Name: keycode_lock

Overview:
- Consumes the single-cycle debounced "0"/"1" key pulses from the key debouncer.
- Assembles them into a CODE_LEN-bit entry and compares it against a fixed code.
- Drives an unlock level on a match. Wrong entries consume tries, and the last try triggers a timed lockout.
- Time-based behaviour counts strobes on the `tick` input, which comes from the shared heartbeat generator, not raw clock cycles.

Parameters:
- CODE_LEN, 4, number of bits per entry (2..16).
- CODE, 4'b1011, secret code, CODE_LEN bits wide. The first key entered is the MSB.
- MAX_TRIES, 3, wrong entries allowed before lockout (1..15).
- TIMEOUT_TICKS, 16, ticks of inactivity in ENTRY before the partial entry is discarded.
- OPEN_TICKS, 8, ticks that unlock stays high.
- LOCK_TICKS, 32, ticks spent in LOCKOUT.

Ports:
- sysclk  in  1  system clock; everything is posedge sysclk.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  timebase strobe, one sysclk cycle wide.
- X0_deb  in  1  debounced "0" key, one-cycle pulse.
- X1_deb  in  1  debounced "1" key, one-cycle pulse.
- unlock  out  1  registered; high while in OPEN.
- alarm  out  1  registered; high while in LOCKOUT.
- err_pulse  out  1  registered; one-cycle pulse on each mismatch.
- entry_cnt  out  clog2(CODE_LEN+1)  number of bits entered so far.
- tries_left  out  4  remaining tries.

Behaviour:
- Reset is asynchronous, active-high, with one clock `sysclk`. On reset, immediately and with no clock edge required:
  - state=IDLE; shift register=0; timer=0.
  - unlock=0, alarm=0, err_pulse=0, entry_cnt=0, tries_left=MAX_TRIES.
- A key event is a cycle in which exactly one of X0_deb/X1_deb is high.
  - Bit value = X1_deb.
  - If both are high in the same cycle, nothing happens: no shift and no timer clear.
- Shift rule: sr <= {sr[CODE_LEN-2:0], bit}; entry_cnt increments.
- IDLE:
  - Timer is held at 0.
  - A key event shifts in the bit, sets entry_cnt=1 and moves to ENTRY.
  - If CODE_LEN=1, a key event goes directly to CHECK.
- ENTRY:
  - A key event shifts in the bit, increments entry_cnt and clears the timer.
  - When entry_cnt reaches CODE_LEN, go to CHECK.
  - Otherwise each tick increments the timer. A key event and a tick in the same cycle resolve in favour of the key, so the timer is cleared.
  - When the timer reaches TIMEOUT_TICKS: sr=0, entry_cnt=0, go to IDLE. tries_left is unchanged and err_pulse is not asserted.
- CHECK (lasts exactly one cycle; key events in this cycle are dropped):
  - Match: go to OPEN; tries_left=MAX_TRIES.
  - Mismatch: err_pulse is high the next cycle; tries_left decrements. Go to LOCKOUT if the new value is 0, otherwise go to IDLE.
  - In both cases sr=0, entry_cnt=0 and the timer is cleared.
- OPEN:
  - unlock=1.
  - Key events are ignored.
  - Ticks increment the timer. When it reaches OPEN_TICKS, go to IDLE with unlock=0.
- LOCKOUT:
  - alarm=1.
  - Key events are ignored.
  - Ticks increment the timer. When it reaches LOCK_TICKS, go to IDLE with alarm=0 and tries_left=MAX_TRIES.
- Latency:
  - If the final key pulse is high in cycle t, unlock (or err_pulse) is high from cycle t+2.
  - alarm follows at t+2 when the final try fails.
- The timer is a single shared counter sized for max(TIMEOUT_TICKS, OPEN_TICKS, LOCK_TICKS). It is cleared on every state change.
- Outputs depend only on registered state, never on raw inputs.

Decomposition:
- Package keycode_pkg holds:
  - State encoding localparams: IDLE, ENTRY, CHECK, OPEN, LOCKOUT (3 bits).
  - The clog2 helper function.
  - The timer-width constant.
- One sub-module is natural: tick_counter.
  - Inputs: sysclk, reset, clr, tick, limit. Output: done.
  - Shared by the timeout, open and lockout timing.
- Top level holds the FSM, shift register, tries counter and output registers.

Test Plan:
All scenarios use the default parameters (CODE=4'b1011, MAX_TRIES=3, TIMEOUT_TICKS=16, OPEN_TICKS=8, LOCK_TICKS=32).
- Keys 1,0,1,1: entry_cnt steps 1,2,3 then 0; unlock rises 2 cycles after the 4th pulse; tries_left=3; unlock falls after 8 ticks.
- Keys 1,1,1,1: err_pulse high for exactly 1 cycle, 2 cycles after the 4th pulse; tries_left=2; unlock stays 0; state returns to IDLE.
- Three wrong entries: tries_left goes 2,1,0; alarm=1. Keys 1,0,1,1 during lockout have no effect. After 32 ticks alarm=0 and tries_left=3, and a correct code then unlocks.
- Inactivity timeout:
  - Keys 1,0 then 16 ticks with no key: entry_cnt=0, tries_left=3, no err_pulse.
  - Repeat with a key on the 15th tick: the timer resets and the entry continues.
- X0_deb and X1_deb both high in the same cycle during ENTRY: entry_cnt is unchanged. A key and a tick in the same cycle leave the timer at 0.
- Async reset asserted mid-cycle with entry_cnt=2, and again during LOCKOUT: all outputs return to reset values before the next sysclk edge; tries_left=3.
